// File: rtl/quad_decoder.sv
// quad_decoder: turns a two-phase A/B quadrature input into step/dir pulses and a
// wrapping position count. A and B are synchronized and glitch-filtered first.
// Latency: an accepted change updates the outputs SYNC_STAGES+FILTER-1 edges after
// it is first captured. There is no backpressure; edges seen while en=0 are dropped.
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   en           allow accepted transitions to update count/step/dir/err
//   clr          synchronous clear of count (wins over a same-cycle step)
//   err_clr      synchronous clear of err (loses to a same-cycle illegal jump)
//   a_in, b_in   raw phase inputs, asynchronous to clk
//   step         one-cycle pulse per legal transition
//   dir          direction of the last legal step (1 = up)
//   count        BITS-wide position, modulo 2^BITS
//   err          sticky flag for a transition where both phases changed

module quad_decoder #(
  parameter int BITS        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic            err_clr,
  input  logic            a_in,
  input  logic            b_in,
  output logic            step,
  output logic            dir,
  output logic [BITS-1:0] count,
  output logic            err
);

  localparam int SW = $clog2(FILTER + 1);
  localparam int WW = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] FILT_N = SW'(FILTER);
  localparam logic [WW-1:0] WARM_N = WW'(SYNC_STAGES);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  // Position of a phase pair along the up sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] f_pos(input logic [1:0] ab);
    logic [1:0] p;
    p = 2'd0;
    case (ab)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // Synchronizers
  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             w_ab_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], a_in};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], b_in};
    end
  end

  assign w_ab_s = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

  // Filter
  // The zeros loaded into the synchronizer by reset are not pin data. Until the
  // chain has been refilled from the pins the filter ignores ab_s, otherwise it
  // could adopt a phantom 00 and flag an illegal jump to the real pin state.
  logic [WW-1:0] r_warm;
  logic          w_live;
  logic [1:0]    r_cand;
  logic [SW-1:0] r_stab;
  logic          w_same;
  logic [SW-1:0] w_run;
  logic          w_acc;

  assign w_live = (r_warm == WARM_N);
  assign w_same = (w_ab_s == r_cand);
  // Length of the current run of equal samples, counting this edge; saturates.
  assign w_run  = w_same ? ((r_stab == FILT_N) ? FILT_N : r_stab + SW'(1)) : SW'(1);
  // Accept exactly once per stable run, on the sample that completes it.
  assign w_acc  = w_live && (w_run == FILT_N) && !(w_same && (r_stab == FILT_N));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_warm <= '0;
      r_cand <= 2'b00;
      r_stab <= '0;
    end else if (!w_live) begin
      r_warm <= r_warm + WW'(1);
    end else begin
      r_cand <= w_ab_s;
      r_stab <= w_run;
    end
  end

  // Decode state machine
  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_filt;
  logic [1:0]      w_filt_nxt;
  logic            r_step;
  logic            w_step_nxt;
  logic            r_dir;
  logic            w_dir_nxt;
  logic [BITS-1:0] r_count;
  logic [BITS-1:0] w_count_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic [1:0]      w_delta;

  // 1 = forward neighbour, 3 = reverse neighbour, 2 = both bits changed.
  assign w_delta = f_pos(w_ab_s) - f_pos(r_filt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_filt  <= 2'b00;
      r_step  <= 1'b0;
      r_dir   <= 1'b1;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_filt  <= w_filt_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = r_filt;
    w_step_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;

    // Clear first so that an illegal jump in the same cycle still sets err.
    if (err_clr) begin
      w_err_nxt = 1'b0;
    end

    if (w_acc) begin
      w_filt_nxt = w_ab_s;
      case (r_state)
        S_INIT: begin
          w_state_nxt = S_TRACK;
        end
        S_TRACK: begin
          if (en) begin
            case (w_delta)
              2'd1: begin
                w_step_nxt  = 1'b1;
                w_dir_nxt   = 1'b1;
                w_count_nxt = r_count + BITS'(1);
              end
              2'd3: begin
                w_step_nxt  = 1'b1;
                w_dir_nxt   = 1'b0;
                w_count_nxt = r_count - BITS'(1);
              end
              2'd2: begin
                w_err_nxt = 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
          w_state_nxt = S_INIT;
        end
      endcase
    end

    // clr overrides the count only; step/dir still report the transition.
    if (clr) begin
      w_count_nxt = '0;
    end
  end

  assign step  = r_step;
  assign dir   = r_dir;
  assign count = r_count;
  assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder with default parameters. Stimulus queues the expected
// step (cycle, dir, count) for each transition; a monitor pops on every step.
module tb_quad_decoder;

  localparam int BITS = 4;
  localparam int SYNC = 2;
  localparam int FILT = 2;
  // Drive at the negedge after posedge c: step is visible after posedge c+LAT.
  localparam int LAT  = SYNC + FILT;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            clr;
  logic            err_clr;
  logic            a_in;
  logic            b_in;
  logic            step;
  logic            dir;
  logic [BITS-1:0] count;
  logic            err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int last_c = 0;

  typedef struct {
    int cyc;
    bit dir;
    int count;
  } exp_t;

  exp_t sb[$];

  quad_decoder #(.BITS(BITS), .SYNC_STAGES(SYNC), .FILTER(FILT)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .err_clr (err_clr),
    .a_in    (a_in),
    .b_in    (b_in),
    .step    (step),
    .dir     (dir),
    .count   (count),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_step: no step by cyc %0d, required step at cyc %0d dir=%0d count=%0d",
               cyc, e.cyc, e.dir, e.count);
    end
    if (!reset && step === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: got step at cyc %0d dir=%0d count=%0d, required no step",
                 cyc, dir, count);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.dir !== dir || e.count != int'(count)) begin
          errors++;
          $display("FAIL step: got cyc=%0d dir=%0d count=%0d, required cyc=%0d dir=%0d count=%0d",
                   cyc, dir, count, e.cyc, e.dir, e.count);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    @(negedge clk);
    a_in   = ab[1];
    b_in   = ab[0];
    last_c = cyc;
  endtask

  task automatic push_step(input int at, input bit d, input int c);
    exp_t e;
    e.cyc   = at;
    e.dir   = d;
    e.count = c;
    sb.push_back(e);
  endtask

  // Drive a new pair and, if a step is expected, queue its hand-computed result.
  task automatic mv(input logic [1:0] ab, input bit st, input bit d, input int c);
    set_ab(ab);
    if (st) push_step(last_c + LAT, d, c);
    wait_cyc(8);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    clr     = 1'b0;
    err_clr = 1'b0;
    a_in    = 1'b1;
    b_in    = 1'b1;

    // 1. Reset values, INIT adoption of 11, then two forward steps
    wait_cyc(3);
    chk("rst_step", 32'(step), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    wait_cyc(10);
    chk("init_count", 32'(count), 0);
    chk("init_err", 32'(err), 0);
    chk("init_dir", 32'(dir), 1);
    mv(2'b10, 1, 1, 1);
    mv(2'b00, 1, 1, 2);
    chk("t1_count", 32'(count), 2);

    // 2. Down to 14, up across the wrap to 2, down across the wrap to 15
    mv(2'b10, 1, 0, 1);
    mv(2'b11, 1, 0, 0);
    mv(2'b01, 1, 0, 15);
    mv(2'b00, 1, 0, 14);
    chk("t2_start", 32'(count), 14);
    mv(2'b01, 1, 1, 15);
    mv(2'b11, 1, 1, 0);
    mv(2'b10, 1, 1, 1);
    mv(2'b00, 1, 1, 2);
    mv(2'b10, 1, 0, 1);
    mv(2'b11, 1, 0, 0);
    mv(2'b01, 1, 0, 15);
    chk("t2_count", 32'(count), 15);
    chk("t2_dir", 32'(dir), 0);

    // 3. Illegal jump 00->11, reverse neighbour 11->01, err_clr, err_clr vs illegal
    mv(2'b00, 1, 0, 14);
    mv(2'b11, 0, 0, 0);
    chk("ill_err", 32'(err), 1);
    chk("ill_count", 32'(count), 14);
    chk("ill_dir", 32'(dir), 0);
    mv(2'b01, 1, 0, 13);
    chk("ill_err_sticky", 32'(err), 1);
    wait_cyc(1);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 0);
    set_ab(2'b10);
    wait_cyc(LAT - 1);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    chk("err_clr_vs_ill", 32'(err), 1);
    wait_cyc(4);
    chk("ill2_count", 32'(count), 13);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    chk("err_clr2", 32'(err), 0);

    // 4. Glitch rejection, then a 3-clock pulse gives +1 then -1
    set_ab(2'b00);
    set_ab(2'b10);
    wait_cyc(8);
    chk("glitch_count", 32'(count), 13);
    chk("glitch_err", 32'(err), 0);
    set_ab(2'b00);
    push_step(last_c + LAT, 1, 14);
    wait_cyc(2);
    set_ab(2'b10);
    push_step(last_c + LAT, 0, 13);
    wait_cyc(8);
    chk("pulse_count", 32'(count), 13);

    // 5. Enable gating, no burst on re-enable, clr with step, clr while disabled
    en = 1'b0;
    mv(2'b00, 0, 0, 0);
    mv(2'b01, 0, 0, 0);
    mv(2'b11, 0, 0, 0);
    chk("dis_count", 32'(count), 13);
    chk("dis_dir", 32'(dir), 0);
    en = 1'b1;
    mv(2'b10, 1, 1, 14);
    set_ab(2'b00);
    push_step(last_c + LAT, 1, 0);
    wait_cyc(LAT - 1);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    wait_cyc(6);
    chk("clr_step_count", 32'(count), 0);
    mv(2'b01, 1, 1, 1);
    mv(2'b11, 1, 1, 2);
    en  = 1'b0;
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    chk("clr_dis_count", 32'(count), 0);
    en = 1'b1;

    // 6. Reset while the filter is counting a new value
    mv(2'b01, 1, 0, 15);
    mv(2'b10, 0, 0, 0);
    chk("pre_rst_err", 32'(err), 1);
    set_ab(2'b00);
    wait_cyc(LAT - 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_step", 32'(step), 0);
    chk("mid_rst_dir", 32'(dir), 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_err", 32'(err), 0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(10);
    chk("readopt_count", 32'(count), 0);
    chk("readopt_err", 32'(err), 0);
    mv(2'b01, 1, 1, 1);
    chk("post_rst_count", 32'(count), 1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
